round_key_store: RTL and testbench

- Double-buffered round-key store directly downstream of the AES-256 key-schedule stage.
- Captures each 256-bit evolved key-schedule word while the schedule is loading and splits it into two 128-bit round keys.
- Holds the 15 round keys of a complete schedule for the cipher datapath, which reads them by index.
- Fills a shadow bank while the cipher runs on the active bank; swaps banks only when the cipher releases its lock.

---
 rtl/aes_key_pkg.sv | 14 +
 rtl/round_key_store_if.sv | 25 ++
 rtl/rk_bank.sv | 34 +++
 rtl/round_key_store.sv | 134 +++++++++++++
 tb/tb_round_key_store.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared widths, round-key type and FSM states for the AES-256 round-key store
package aes_key_pkg;
  localparam int RK_W   = 128;
  localparam int NUM_RK = 15;
  localparam int KS_W   = 2 * RK_W;

  typedef logic [RK_W-1:0] rk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } rks_state_t;
endpackage

// File: rtl/round_key_store_if.sv
// rtl/round_key_store_if.sv - schedule-load and round-key read bundle between key schedule, store and cipher
interface round_key_store_if
  import aes_key_pkg::*;
;
  logic            ks_load;
  logic [2:0]      ks_round;
  logic [KS_W-1:0] ks_out;
  logic            rd_lock;
  logic [3:0]      rd_idx;
  rk_t             rd_data;
  logic            keys_valid;
  logic            fill_busy;
  logic            swap_pulse;
  logic            seq_err;

  modport master (
    output ks_load, ks_round, ks_out, rd_lock, rd_idx,
    input  rd_data, keys_valid, fill_busy, swap_pulse, seq_err
  );

  modport slave (
    input  ks_load, ks_round, ks_out, rd_lock, rd_idx,
    output rd_data, keys_valid, fill_busy, swap_pulse, seq_err
  );
endinterface

// File: rtl/rk_bank.sv
// rtl/rk_bank.sv - one bank of round keys: dual-slot write of a schedule word, combinational read mux
module rk_bank #(
  parameter int RK_W   = 128,
  parameter int NUM_RK = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              we_i,
  input  logic [2:0]        round_i,
  input  logic [2*RK_W-1:0] data_i,
  input  logic [3:0]        idx_i,
  output logic [RK_W-1:0]   rd_o
);
  localparam logic [3:0] NUM_RK_L = 4'(NUM_RK);

  logic [RK_W-1:0] mem_q [NUM_RK];

  // Slot 2r+1 for the last round falls off the end of the array and is dropped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_RK; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (4'(i) == {round_i, 1'b0}) begin
          mem_q[i] <= data_i[2*RK_W-1:RK_W];
        end else if (4'(i) == {round_i, 1'b1}) begin
          mem_q[i] <= data_i[RK_W-1:0];
        end
      end
    end
  end

  assign rd_o = (idx_i < NUM_RK_L) ? mem_q[idx_i] : '0;
endmodule

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - double-buffered AES-256 round-key store; KS_SEQ_CHECK_EN enables sequence checking
module round_key_store
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  round_key_store_if.slave bus
);
  rks_state_t state_q, state_d;
  logic       bank_sel_q;
  logic       keys_valid_q;
  logic       swap_pulse_q;
  rk_t        rd_data_q;
  logic       wr_en;
  logic       swap;
  rk_t        rd0, rd1;
`ifdef KS_SEQ_CHECK_EN
  logic       err_set;
  logic       seq_err_q;
  logic [2:0] prev_round_q;
`endif

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    swap    = 1'b0;
`ifdef KS_SEQ_CHECK_EN
    err_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ks_load && bus.ks_round == 3'd0) begin
          wr_en   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!bus.ks_load) begin
          state_d = IDLE;
`ifdef KS_SEQ_CHECK_EN
          err_set = 1'b1;
`endif
        end else if (bus.ks_round == 3'd0) begin
          wr_en = 1'b1;
`ifdef KS_SEQ_CHECK_EN
        end else if (bus.ks_round != prev_round_q + 3'd1) begin
          err_set = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          wr_en = 1'b1;
          if (bus.ks_round == 3'd7) begin
            if (bus.rd_lock) begin
              state_d = PEND;
            end else begin
              swap    = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      PEND: begin
        // A lock release wins over a simultaneous restart word.
        if (!bus.rd_lock) begin
          swap    = 1'b1;
          state_d = IDLE;
        end else if (bus.ks_load && bus.ks_round == 3'd0) begin
          wr_en   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bank_sel_q   <= 1'b0;
      keys_valid_q <= 1'b0;
      swap_pulse_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      swap_pulse_q <= swap;
      // Sampled with the pre-swap select, so the swap edge still reads the old bank.
      rd_data_q    <= bank_sel_q ? rd1 : rd0;
      if (swap) begin
        bank_sel_q   <= ~bank_sel_q;
        keys_valid_q <= 1'b1;
      end
    end
  end

`ifdef KS_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      seq_err_q    <= 1'b0;
      prev_round_q <= 3'd0;
    end else begin
      if (err_set) seq_err_q <= 1'b1;
      if (wr_en) prev_round_q <= bus.ks_round;
    end
  end
  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  rk_bank #(.RK_W(RK_W), .NUM_RK(NUM_RK)) u_bank0 (
    .clk     (clk),
    .n_rst   (n_rst),
    .we_i    (wr_en & bank_sel_q),
    .round_i (bus.ks_round),
    .data_i  (bus.ks_out),
    .idx_i   (bus.rd_idx),
    .rd_o    (rd0)
  );

  rk_bank #(.RK_W(RK_W), .NUM_RK(NUM_RK)) u_bank1 (
    .clk     (clk),
    .n_rst   (n_rst),
    .we_i    (wr_en & ~bank_sel_q),
    .round_i (bus.ks_round),
    .data_i  (bus.ks_out),
    .idx_i   (bus.rd_idx),
    .rd_o    (rd1)
  );

  assign bus.rd_data    = rd_data_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.fill_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - randomized self-checking bench for round_key_store against a bank-level model
module tb_round_key_store;
  import aes_key_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  round_key_store_if bus();

  round_key_store dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  swap_cnt = 0;
  rk_t exp_act [NUM_RK];
  rk_t exp_shd [NUM_RK];
  logic exp_seq_err;

  always @(posedge clk) begin
    #1;
    if (bus.swap_pulse === 1'b1) swap_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rk_t exp_rd(input logic [3:0] idx);
    return (int'(idx) < NUM_RK) ? exp_act[idx] : '0;
  endfunction

  function automatic logic [KS_W-1:0] make_word(input bit det, input int r);
    logic [KS_W-1:0] w;
    if (det) begin
      w = {128'(2 * r), 128'(2 * r + 1)};
    end else begin
      w = '0;
      for (int k = 0; k < KS_W / 32; k++) w = {w[KS_W-33:0], 32'($urandom)};
    end
    return w;
  endfunction

  task automatic do_read(input logic [3:0] idx, input string tag);
    bus.rd_idx = idx;
    @(negedge clk);
    check(tag, bus.rd_data, exp_rd(idx));
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 16; k++) do_read(4'(k), tag);
  endtask

  // Presents one word for one cycle with a random read alongside; the active bank must be unaffected.
  task automatic send_word(input int r, input logic [KS_W-1:0] w);
    logic [3:0] idx;
    idx = 4'($urandom_range(0, 15));
    bus.ks_load  = 1'b1;
    bus.ks_round = 3'(r);
    bus.ks_out   = w;
    bus.rd_idx   = idx;
    @(negedge clk);
    check("rd_during_fill", bus.rd_data, exp_rd(idx));
    exp_shd[2 * r] = w[KS_W-1:RK_W];
    if (2 * r + 1 < NUM_RK) exp_shd[2 * r + 1] = w[RK_W-1:0];
  endtask

  task automatic fill(input bit det, input bit lock, input int restart_at);
    bus.rd_lock = lock;
    for (int r = 0; r < restart_at; r++) begin
      send_word(r, make_word(det, r));
      check("busy_pre_restart", bus.fill_busy, 1'b1);
    end
    for (int r = 0; r < 8; r++) begin
      send_word(r, make_word(det, r));
      if (r < 7) begin
        check("busy_mid_fill", bus.fill_busy, 1'b1);
        check("no_pulse_mid_fill", bus.swap_pulse, 1'b0);
      end
    end
    bus.ks_load = 1'b0;
    if (!lock) begin
      check("swap_pulse_after_r7", bus.swap_pulse, 1'b1);
      check("idle_after_swap", bus.fill_busy, 1'b0);
      check("keys_valid_after_swap", bus.keys_valid, 1'b1);
      exp_act = exp_shd;
      @(negedge clk);
      check("swap_pulse_one_cycle", bus.swap_pulse, 1'b0);
    end else begin
      check("pend_busy", bus.fill_busy, 1'b1);
      check("pend_no_pulse", bus.swap_pulse, 1'b0);
    end
  endtask

  initial begin
    int base;
    n_rst        = 1'b0;
    bus.ks_load  = 1'b0;
    bus.ks_round = 3'd0;
    bus.ks_out   = '0;
    bus.rd_lock  = 1'b0;
    bus.rd_idx   = 4'd0;
    exp_seq_err  = 1'b0;
    for (int k = 0; k < NUM_RK; k++) begin
      exp_act[k] = '0;
      exp_shd[k] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_rd_data", bus.rd_data, '0);
    check("reset_keys_valid", bus.keys_valid, 1'b0);
    check("reset_fill_busy", bus.fill_busy, 1'b0);
    check("reset_swap_pulse", bus.swap_pulse, 1'b0);
    check("reset_seq_err", bus.seq_err, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);

    // Known-pattern schedule: slot k holds k.
    fill(1'b1, 1'b0, 0);
    read_all("t1_read");
    check("t1_swap_count", 32'(swap_cnt), 1);

    // Fill while locked; the old bank stays visible until release.
    fill(1'b0, 1'b1, 0);
    for (int c = 0; c < 10; c++) begin
      do_read(4'($urandom_range(0, 15)), "t2_read_locked");
      check("t2_pend_busy", bus.fill_busy, 1'b1);
    end
    check("t2_no_swap_while_locked", 32'(swap_cnt), 1);
    bus.rd_lock = 1'b0;
    bus.rd_idx  = 4'($urandom_range(0, 14));
    @(negedge clk);
    check("t2_read_on_swap_edge_old", bus.rd_data, exp_rd(bus.rd_idx));
    check("t2_swap_pulse", bus.swap_pulse, 1'b1);
    check("t2_idle", bus.fill_busy, 1'b0);
    exp_act = exp_shd;
    read_all("t2_read_new");
    check("t2_swap_count", 32'(swap_cnt), 2);

    // Back-to-back schedule with random data.
    fill(1'b0, 1'b0, 0);
    read_all("t3_read");
    check("t3_swap_count", 32'(swap_cnt), 3);

    // Restart at what would have been round 4.
    fill(1'b0, 1'b0, 4);
    read_all("t4_read");
    check("t4_single_swap", 32'(swap_cnt), 4);

    // Abort after round 3.
    base = swap_cnt;
    for (int r = 0; r < 4; r++) send_word(r, make_word(1'b0, r));
    bus.ks_load = 1'b0;
    @(negedge clk);
`ifdef KS_SEQ_CHECK_EN
    exp_seq_err = 1'b1;
`endif
    check("t5_abort_idle", bus.fill_busy, 1'b0);
    check("t5_seq_err", bus.seq_err, exp_seq_err);
    check("t5_no_swap", 32'(swap_cnt), 32'(base));
    check("t5_keys_valid", bus.keys_valid, 1'b1);
    read_all("t5_read_old");

    // Reset while a swap is pending.
    fill(1'b0, 1'b1, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("t6_rd_data", bus.rd_data, '0);
    check("t6_keys_valid", bus.keys_valid, 1'b0);
    check("t6_swap_pulse", bus.swap_pulse, 1'b0);
    check("t6_fill_busy", bus.fill_busy, 1'b0);
    check("t6_seq_err", bus.seq_err, 1'b0);
    for (int k = 0; k < NUM_RK; k++) exp_act[k] = '0;
    @(negedge clk);
    n_rst       = 1'b1;
    bus.rd_lock = 1'b0;
    @(negedge clk);
    read_all("t6_read_cleared");
    check("t6_keys_valid_after", bus.keys_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
